grad_dump_sched: RTL and testbench

GRAD_DUMP_SCHED -- requirements
Module: grad_dump_sched

---
 rtl/grad_dump_sched.sv | 168 ++++++++++++++++
 tb/tb_grad_dump_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grad_dump_sched.sv
// Gradient dump scheduler: streams the x and y gradient planes from BRAM as
// framed bytes (A5, plane id, N samples per plane) over a valid/ready link.
module grad_dump_sched #(
    parameter int WIDTH      = 64,
    parameter int HEIGHT     = 64,
    parameter int BIT_DEPTH  = 8,
    parameter int RD_LATENCY = 2,
    localparam int N  = WIDTH * HEIGHT,
    localparam int AW = $clog2(N)
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic                 grad_ready_in,
    input  logic                 abort_in,
    output logic [AW-1:0]        rd_addr_o,
    input  logic [BIT_DEPTH-1:0] x_data_in,
    input  logic [BIT_DEPTH-1:0] y_data_in,
    output logic [BIT_DEPTH-1:0] tx_data_o,
    output logic                 tx_valid_o,
    input  logic                 tx_ready_in,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2:0]           state_o
);

    localparam int WW = (RD_LATENCY > 0) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [BIT_DEPTH-1:0] SYNC_BYTE = BIT_DEPTH'(8'hA5);
    localparam logic [AW-1:0]        LAST_PIX  = AW'(N - 1);
    localparam logic [WW-1:0]        WAIT_LAST = WW'(RD_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SYNC  = 3'd1,
        S_ID    = 3'd2,
        S_FETCH = 3'd3,
        S_SEND  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_plane, w_plane_nxt;
    logic [AW-1:0]        r_cnt, w_cnt_nxt;
    logic [WW-1:0]        r_wait, w_wait_nxt;
    logic [BIT_DEPTH-1:0] r_tx_data, w_data_nxt;
    logic                 r_abort, w_abort_nxt;
    logic                 w_accept;
    logic                 w_abort;

    assign tx_valid_o = (r_state == S_SYNC) || (r_state == S_ID) || (r_state == S_SEND);
    assign w_accept   = tx_valid_o && tx_ready_in;
    // An abort seen while a byte is held is remembered until that byte is accepted.
    assign w_abort    = abort_in || r_abort;

    assign rd_addr_o  = r_cnt;
    assign tx_data_o  = r_tx_data;
    assign busy_o     = (r_state != S_IDLE);
    assign done_o     = (r_state == S_DONE);
    assign state_o    = r_state;

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state   <= S_IDLE;
            r_plane   <= 1'b0;
            r_cnt     <= '0;
            r_wait    <= '0;
            r_tx_data <= '0;
            r_abort   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_plane   <= w_plane_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wait    <= w_wait_nxt;
            r_tx_data <= w_data_nxt;
            r_abort   <= w_abort_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_plane_nxt = r_plane;
        w_cnt_nxt   = r_cnt;
        w_wait_nxt  = r_wait;
        w_data_nxt  = r_tx_data;
        w_abort_nxt = r_abort;

        unique case (r_state)
            S_IDLE: begin
                w_abort_nxt = 1'b0;
                if (start_in && grad_ready_in) begin
                    w_state_nxt = S_SYNC;
                    w_plane_nxt = 1'b0;
                    w_cnt_nxt   = '0;
                    w_data_nxt  = SYNC_BYTE;
                end
            end
            S_SYNC: begin
                if (w_accept) begin
                    if (w_abort) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_ID;
                        w_data_nxt  = {{(BIT_DEPTH-1){1'b0}}, r_plane};
                    end
                end else if (abort_in) begin
                    w_abort_nxt = 1'b1;
                end
            end
            S_ID: begin
                if (w_accept) begin
                    if (w_abort) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_cnt_nxt   = '0;
                        w_wait_nxt  = '0;
                    end
                end else if (abort_in) begin
                    w_abort_nxt = 1'b1;
                end
            end
            S_FETCH: begin
                if (abort_in) begin
                    w_state_nxt = S_IDLE;
                end else if (r_wait == WAIT_LAST) begin
                    w_state_nxt = S_SEND;
                    w_data_nxt  = r_plane ? y_data_in : x_data_in;
                end else begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            S_SEND: begin
                if (w_accept) begin
                    // The final y byte completes the dump even if an abort arrives with it.
                    if (r_cnt == LAST_PIX) begin
                        if (r_plane) begin
                            w_state_nxt = S_DONE;
                        end else if (w_abort) begin
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_state_nxt = S_SYNC;
                            w_plane_nxt = 1'b1;
                            w_cnt_nxt   = '0;
                            w_data_nxt  = SYNC_BYTE;
                        end
                    end else if (w_abort) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_wait_nxt  = '0;
                    end
                end else if (abort_in) begin
                    w_abort_nxt = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_grad_dump_sched.sv
// Self-checking bench for grad_dump_sched: a BRAM model feeds both planes and the
// accepted byte stream is compared with a frame built directly from the plane contents.
module tb_grad_dump_sched;

    localparam int WIDTH  = 4;
    localparam int HEIGHT = 2;
    localparam int BD     = 8;
    localparam int RL     = 2;
    localparam int N      = WIDTH * HEIGHT;
    localparam int AW     = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          grad_ready = 1'b0;
    logic          abort = 1'b0;
    logic          tx_ready = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [BD-1:0] x_data, y_data, tx_data;
    logic          tx_valid, busy, done;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;

    logic [7:0] x_mem [N];
    logic [7:0] y_mem [N];
    logic [7:0] xp [RL];
    logic [7:0] yp [RL];
    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int         done_cnt = 0;
    int         ready_mode = 2;   // 0: tied high, 1: random 30%, 2: driven by the test

    grad_dump_sched #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BIT_DEPTH(BD), .RD_LATENCY(RL)
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .grad_ready_in(grad_ready),
        .abort_in(abort), .rd_addr_o(rd_addr), .x_data_in(x_data), .y_data_in(y_data),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_in(tx_ready),
        .busy_o(busy), .done_o(done), .state_o(state)
    );

    always #5 clk = ~clk;

    // BRAM model: read data appears RL clocks after the address.
    always @(posedge clk) begin
        xp[0] <= x_mem[rd_addr];
        yp[0] <= y_mem[rd_addr];
        for (int k = 1; k < RL; k++) begin
            xp[k] <= xp[k-1];
            yp[k] <= yp[k-1];
        end
    end
    assign x_data = xp[RL-1];
    assign y_data = yp[RL-1];

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (ready_mode == 0)      tx_ready = 1'b1;
            else if (ready_mode == 1) tx_ready = ($urandom_range(0, 99) < 30);
        end
    end

    // Stream monitor: records accepted bytes, done pulses, hold stability and FETCH address stability.
    logic          prev_hold = 1'b0;
    logic [7:0]    prev_data = '0;
    logic [2:0]    prev_state = '0;
    logic [AW-1:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rst) begin
            if (prev_hold) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (prev_state == 3'd3 && state == 3'd3) begin
                checks++;
                if (rd_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL fetch_addr_stable: addr=%0d, required %0d", rd_addr, prev_addr);
                end
            end
            if (tx_valid && tx_ready) got.push_back(tx_data);
            if (done) done_cnt++;
        end
        prev_hold  = rst && tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_state = rst ? state : 3'd0;
        prev_addr  = rd_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_directed();
        for (int i = 0; i < N; i++) begin
            x_mem[i] = 8'h10 + 8'(i);
            y_mem[i] = 8'h80 + 8'(i);
        end
    endtask

    task automatic build_exp();
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        for (int i = 0; i < N; i++) exp_q.push_back(x_mem[i]);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h01);
        for (int i = 0; i < N; i++) exp_q.push_back(y_mem[i]);
    endtask

    task automatic begin_dump();
        got.delete();
        done_cnt = 0;
        grad_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_dump(input string name, input int mode, input bit pulse_mid);
        int cyc;
        int mid_at;
        build_exp();
        ready_mode = mode;
        begin_dump();
        mid_at = $urandom_range(10, 60);
        cyc = 0;
        while (busy && cyc < 3000) begin
            start = (pulse_mid && cyc == mid_at);
            tick();
            cyc++;
        end
        start = 1'b0;
        checks++;
        if (cyc >= 3000) begin
            errors++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles", name, busy, cyc);
        end
        repeat (5) tick();
        checks++;
        if (got.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_count: %0d bytes, required %0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h, required %h", name, i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done pulses=%0d busy=%b, required 1 and 0", name, done_cnt, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if ({state, tx_valid, busy, done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d valid=%b busy=%b done=%b, required all 0",
                     state, tx_valid, busy, done);
        end
        checks++;
        if (rd_addr !== '0 || tx_data !== '0) begin
            errors++;
            $display("FAIL reset_data: addr=%0d data=%h, required 0 and 00", rd_addr, tx_data);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_no_grad_ready();
        int bad = 0;
        ready_mode = 0;
        grad_ready = 1'b0;
        got.delete();
        start = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c == 3) start = 1'b0;
            tick();
            if (tx_valid || busy) bad++;
        end
        start = 1'b0;
        checks++;
        if (bad !== 0 || got.size() !== 0) begin
            errors++;
            $display("FAIL no_grad_ready: %0d active cycles %0d bytes, required 0 and 0", bad, got.size());
        end
    endtask

    task automatic wait_for(input string name, input logic [2:0] st, input int addr, input int nbytes);
        int cyc = 0;
        while (!(state == st && (addr < 0 || rd_addr == AW'(addr)) && got.size() == nbytes) && cyc < 500) begin
            tick();
            cyc++;
        end
        checks++;
        if (cyc >= 500) begin
            errors++;
            $display("FAIL %s_reach: state=%0d addr=%0d bytes=%0d, required state %0d", name, state,
                     rd_addr, got.size(), st);
        end
    endtask

    task automatic test_abort_send();
        ready_mode = 2;
        tx_ready = 1'b1;
        begin_dump();
        wait_for("abort_send", 3'd4, 3, 5);
        tx_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h13) begin
            errors++;
            $display("FAIL abort_hold: valid=%b data=%h, required 1 and 13", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        tick();
        checks++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: state=%0d busy=%b, required 0 and 0", state, busy);
        end
        repeat (10) tick();
        checks++;
        if (done_cnt !== 0 || got.size() !== 6) begin
            errors++;
            $display("FAIL abort_stream: done=%0d bytes=%0d, required 0 and 6", done_cnt, got.size());
        end else begin
            checks++;
            if (got[5] !== 8'h13) begin
                errors++;
                $display("FAIL abort_last_byte: got %h, required 13", got[5]);
            end
        end
        run_dump("abort_restart", 0, 1'b0);
    endtask

    task automatic test_abort_fetch();
        ready_mode = 2;
        tx_ready = 1'b1;
        begin_dump();
        wait_for("abort_fetch", 3'd3, -1, 2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (state !== 3'd0 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_fetch_idle: state=%0d valid=%b, required 0 and 0", state, tx_valid);
        end
        repeat (10) tick();
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_fetch_done: done=%0d busy=%b, required 0 and 0", done_cnt, busy);
        end
    endtask

    task automatic test_abort_last();
        ready_mode = 2;
        tx_ready = 1'b1;
        begin_dump();
        wait_for("abort_last", 3'd4, N - 1, 2 * N + 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (state !== 3'd5) begin
            errors++;
            $display("FAIL abort_last_state: state=%0d, required 5", state);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt !== 1 || got.size() !== 2 * (N + 2) || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_last_done: done=%0d bytes=%0d busy=%b, required 1, %0d, 0",
                     done_cnt, got.size(), busy, 2 * (N + 2));
        end
    endtask

    task automatic test_reset_mid();
        ready_mode = 2;
        tx_ready = 1'b1;
        begin_dump();
        wait_for("reset_mid", 3'd3, 2, N + 6);
        rst = 1'b0;
        tick();
        checks++;
        if ({state, tx_valid, busy, done} !== 6'b0 || rd_addr !== '0 || tx_data !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: state=%0d valid=%b busy=%b done=%b addr=%0d data=%h, required all 0",
                     state, tx_valid, busy, done, rd_addr, tx_data);
        end
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_done: done=%0d busy=%b, required 0 and 0", done_cnt, busy);
        end
        run_dump("after_reset", 1, 1'b0);
    endtask

    task automatic test_random_data();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                x_mem[i] = 8'($urandom);
                y_mem[i] = 8'($urandom);
            end
            run_dump($sformatf("random_data%0d", r), 1, 1'b0);
        end
        load_directed();
    endtask

    initial begin
        load_directed();
        test_reset();
        run_dump("ready_tied", 0, 1'b0);
        run_dump("ready_random", 1, 1'b0);
        test_no_grad_ready();
        test_abort_send();
        test_abort_fetch();
        test_abort_last();
        test_reset_mid();
        run_dump("start_mid", 1, 1'b1);
        test_random_data();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
